// File: rtl/button_scan_controller.sv
// Round-robin debounce controller: one shared counter services NUM_BUTTONS inputs
// and latches sticky press flags that the CPU clears with a write-1-to-clear mask.
module button_scan_controller #(
  parameter int unsigned NUM_BUTTONS   = 16,
  parameter int unsigned COUNTER_SIZE  = 8,
  parameter int unsigned COUNTER_VALUE = 255,
  localparam int unsigned IDX_W        = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  input  logic                   clear_valid,
  input  logic [NUM_BUTTONS-1:0] clear_mask,
  output logic [NUM_BUTTONS-1:0] buttons_out,
  output logic                   busy,
  output logic [IDX_W-1:0]       active_index
);

  typedef enum logic {
    SCAN  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_BUTTONS - 1);
  localparam logic [COUNTER_SIZE-1:0] THRESHOLD  = COUNTER_SIZE'(COUNTER_VALUE);

  state_t                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        sel_q;
  logic [COUNTER_SIZE-1:0] counter_q;
  logic [NUM_BUTTONS-1:0]  buttons_out_q;

  logic [NUM_BUTTONS-1:0]  eligible;
  logic                    scan_found;
  logic [IDX_W-1:0]        scan_idx;
  logic [IDX_W-1:0]        cand_idx;
  int unsigned             cand;
  logic [IDX_W-1:0]        next_ptr;
  logic                    sel_held;
  logic                    at_threshold;
  logic                    latch_press;
  logic [NUM_BUTTONS-1:0]  set_vec;
  logic [NUM_BUTTONS-1:0]  clr_vec;

  assign eligible = buttons_in & ~buttons_out_q;

  // First eligible button at or after ptr, searching upward with wrap.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_BUTTONS; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_BUTTONS) begin
        cand = cand - NUM_BUTTONS;
      end
      cand_idx = IDX_W'(cand);
      if (!scan_found && eligible[cand_idx]) begin
        scan_found = 1'b1;
        scan_idx   = cand_idx;
      end
    end
  end

  assign next_ptr     = (sel_q == LAST_IDX) ? '0 : sel_q + IDX_W'(1);
  assign sel_held     = buttons_in[sel_q];
  assign at_threshold = (counter_q == THRESHOLD);
  assign latch_press  = (state_q == COUNT) && sel_held && at_threshold;

  // Set is OR-ed after the clear so a coincident press is never lost.
  assign set_vec = latch_press ? (NUM_BUTTONS'(1) << sel_q) : '0;
  assign clr_vec = clear_valid ? clear_mask : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCAN;
      ptr_q         <= '0;
      sel_q         <= '0;
      counter_q     <= '0;
      buttons_out_q <= '0;
    end else begin
      buttons_out_q <= (buttons_out_q & ~clr_vec) | set_vec;
      case (state_q)
        SCAN: begin
          if (scan_found) begin
            sel_q     <= scan_idx;
            counter_q <= '0;
            state_q   <= COUNT;
          end
        end
        COUNT: begin
          if (!sel_held || at_threshold) begin
            counter_q <= '0;
            ptr_q     <= next_ptr;
            state_q   <= SCAN;
          end else begin
            counter_q <= counter_q + COUNTER_SIZE'(1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign buttons_out  = buttons_out_q;
  assign busy         = (state_q == COUNT);
  assign active_index = sel_q;

endmodule

// File: tb/tb_button_scan_controller.sv
// Directed bench for button_scan_controller with 4 buttons and a threshold of 3.
module tb_button_scan_controller;

  localparam int unsigned NB = 4;
  localparam int unsigned CS = 4;
  localparam int unsigned CV = 3;
  localparam int unsigned IW = 2;

  logic          clk;
  logic          reset;
  logic [NB-1:0] buttons_in;
  logic          clear_valid;
  logic [NB-1:0] clear_mask;
  logic [NB-1:0] buttons_out;
  logic          busy;
  logic [IW-1:0] active_index;

  int n_cmp;
  int n_err;

  button_scan_controller #(
    .NUM_BUTTONS  (NB),
    .COUNTER_SIZE (CS),
    .COUNTER_VALUE(CV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons_in  (buttons_in),
    .clear_valid (clear_valid),
    .clear_mask  (clear_mask),
    .buttons_out (buttons_out),
    .busy        (busy),
    .active_index(active_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input logic [NB-1:0] e_out,
                            input logic e_busy, input logic [IW-1:0] e_idx);
    check_eq({tag, ".out"},  16'(buttons_out),  16'(e_out));
    check_eq({tag, ".busy"}, 16'(busy),         16'(e_busy));
    check_eq({tag, ".idx"},  16'(active_index), 16'(e_idx));
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    buttons_in  = '0;
    clear_valid = 1'b0;
    clear_mask  = '0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    buttons_in  = 4'b1111;
    clear_valid = 1'b0;
    clear_mask  = 4'b0000;

    // Reset held two edges with every button pressed
    tick(2);
    check_outs("reset", 4'b0000, 1'b0, 2'd0);
    reset = 1'b0;
    tick(1);
    check_outs("first_sel", 4'b0000, 1'b1, 2'd0);

    // Single press of button 2
    do_reset();
    buttons_in = 4'b0100;
    tick(1);
    check_outs("single.e0", 4'b0000, 1'b1, 2'd2);
    tick(3);
    check_outs("single.e3", 4'b0000, 1'b1, 2'd2);
    tick(1);
    check_outs("single.e4", 4'b0100, 1'b0, 2'd2);
    tick(2);
    check_outs("single.hold", 4'b0100, 1'b0, 2'd2);

    // Glitch on button 1; ptr must move to 2 afterwards
    do_reset();
    buttons_in = 4'b0010;
    tick(1);
    check_outs("glitch.e0", 4'b0000, 1'b1, 2'd1);
    tick(1);
    buttons_in = 4'b0000;
    tick(1);
    check_outs("glitch.rel", 4'b0000, 1'b0, 2'd1);
    buttons_in = 4'b0110;
    tick(1);
    check_outs("glitch.ptr", 4'b0000, 1'b1, 2'd2);

    // Round-robin between buttons 0 and 3, then ptr wrap back to 0
    do_reset();
    buttons_in = 4'b1001;
    tick(1);
    check_outs("rr.e0", 4'b0000, 1'b1, 2'd0);
    tick(4);
    check_outs("rr.e4", 4'b0001, 1'b0, 2'd0);
    tick(1);
    check_outs("rr.e5", 4'b0001, 1'b1, 2'd3);
    tick(4);
    check_outs("rr.e9", 4'b1001, 1'b0, 2'd3);
    clear_valid = 1'b1;
    clear_mask  = 4'b1001;
    tick(1);
    clear_valid = 1'b0;
    clear_mask  = 4'b0000;
    check_outs("rr.clr", 4'b0000, 1'b0, 2'd3);
    tick(1);
    check_outs("rr.wrap", 4'b0000, 1'b1, 2'd0);

    // Clear while held, then full re-debounce
    do_reset();
    buttons_in = 4'b0100;
    tick(5);
    check_outs("rearm.lat", 4'b0100, 1'b0, 2'd2);
    clear_mask = 4'b0100;
    tick(1);
    check_outs("rearm.nov", 4'b0100, 1'b0, 2'd2);
    clear_valid = 1'b1;
    tick(1);
    clear_valid = 1'b0;
    clear_mask  = 4'b0000;
    check_outs("rearm.clr", 4'b0000, 1'b0, 2'd2);
    tick(1);
    check_outs("rearm.sel", 4'b0000, 1'b1, 2'd2);
    tick(3);
    check_outs("rearm.e3", 4'b0000, 1'b1, 2'd2);
    tick(1);
    check_outs("rearm.e4", 4'b0100, 1'b0, 2'd2);

    // Clear coinciding with the latching edge: set wins
    do_reset();
    buttons_in = 4'b0100;
    tick(4);
    clear_valid = 1'b1;
    clear_mask  = 4'b0100;
    tick(1);
    clear_valid = 1'b0;
    clear_mask  = 4'b0000;
    check_outs("setwins", 4'b0100, 1'b0, 2'd2);

    // Reset mid-count abandons the count; debounce restarts after release
    do_reset();
    buttons_in = 4'b0010;
    tick(2);
    check_outs("rmid.e1", 4'b0000, 1'b1, 2'd1);
    reset       = 1'b1;
    clear_valid = 1'b1;
    clear_mask  = 4'b1111;
    tick(1);
    clear_valid = 1'b0;
    clear_mask  = 4'b0000;
    check_outs("rmid.rst", 4'b0000, 1'b0, 2'd0);
    reset = 1'b0;
    tick(1);
    check_outs("rmid.sel", 4'b0000, 1'b1, 2'd1);
    tick(3);
    check_outs("rmid.e3", 4'b0000, 1'b1, 2'd1);
    tick(1);
    check_outs("rmid.e4", 4'b0010, 1'b0, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
